// File: rtl/ro_freq_counter.sv
// ro_freq_counter: gated ring-oscillator edge counter with a one-cycle done pulse.
// The optional self-test stimulus mode is built when RO_SELFTEST_EN is defined.
module ro_freq_counter #(
   parameter int unsigned COUNT_W       = 16,
   parameter int unsigned GATE_W        = 24,
   parameter int unsigned SETTLE_CYCLES = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   input  logic [GATE_W-1:0]  gate_len,
   input  logic               ro_clk,
`ifdef RO_SELFTEST_EN
   input  logic               selftest,
`endif
   output logic               ro_en,
   output logic               ro_sel,
   output logic               busy,
   output logic               done,
   output logic [COUNT_W-1:0] count,
   output logic               overflow
);

   localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ARM, S_GATE, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [SET_W-1:0]   set_q, set_d;
   logic [GATE_W-1:0]  gate_q, gate_d;
   logic               sync1_q, sync1_d;
   logic               sync2_q, sync2_d;
   logic               prev_q, prev_d;
   logic               edge_q, edge_d;
   logic [COUNT_W-1:0] count_q, count_d;
   logic               ovf_q, ovf_d;
   logic               ro_en_q, ro_en_d;
   logic               ro_sel_q, ro_sel_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
`ifdef RO_SELFTEST_EN
   logic               st_q, st_d;
   logic [1:0]         ph_q, ph_d;
`endif

   // Next-state, counters, synchronizer chain and registered-output decode.
   always_comb begin
      state_d  = state_q;
      set_d    = set_q;
      gate_d   = gate_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      sync1_d  = ro_clk;
      sync2_d  = sync1_q;
      prev_d   = sync2_q;
      edge_d   = sync2_q & ~prev_q;
`ifdef RO_SELFTEST_EN
      st_d     = st_q;
      ph_d     = ph_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_ARM;
               set_d   = SET_W'(SETTLE_CYCLES - 1);
               gate_d  = gate_len;
               count_d = '0;
               ovf_d   = 1'b0;
`ifdef RO_SELFTEST_EN
               st_d    = selftest;
`endif
            end
         end
         S_ARM: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (set_q == '0) begin
               state_d = (gate_q == '0) ? S_DONE : S_GATE;
            end else begin
               set_d = set_q - SET_W'(1);
            end
         end
         S_GATE: begin
            // Saturating edge count; overflow marks an edge lost at all-ones.
            if (edge_q) begin
               if (&count_q) ovf_d   = 1'b1;
               else          count_d = count_q + COUNT_W'(1);
            end
            if (abort) begin
               state_d = S_IDLE;
            end else if (gate_q == GATE_W'(1)) begin
               state_d = S_DONE;
            end else begin
               gate_d = gate_q - GATE_W'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d   = (state_d == S_ARM) || (state_d == S_GATE);
      done_d   = (state_d == S_DONE);
`ifdef RO_SELFTEST_EN
      // Self-test keeps the loop open and toggles ro_en every 2 cycles from the first ARM cycle.
      ph_d     = (state_q == S_IDLE) ? 2'd0 : (busy_d ? ph_q + 2'd1 : ph_q);
      ro_sel_d = ~busy_d | st_d;
      ro_en_d  = st_d & busy_d & ~ph_d[1];
`else
      ro_sel_d = ~busy_d;
      ro_en_d  = 1'b0;
`endif
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         set_q    <= '0;
         gate_q   <= '0;
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         prev_q   <= 1'b0;
         edge_q   <= 1'b0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         ro_en_q  <= 1'b0;
         ro_sel_q <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef RO_SELFTEST_EN
         st_q     <= 1'b0;
         ph_q     <= 2'd0;
`endif
      end else begin
         state_q  <= state_d;
         set_q    <= set_d;
         gate_q   <= gate_d;
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         prev_q   <= prev_d;
         edge_q   <= edge_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         ro_en_q  <= ro_en_d;
         ro_sel_q <= ro_sel_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
`ifdef RO_SELFTEST_EN
         st_q     <= st_d;
         ph_q     <= ph_d;
`endif
      end
   end

   assign ro_en    = ro_en_q;
   assign ro_sel   = ro_sel_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign count    = count_q;
   assign overflow = ovf_q;

endmodule
